// File: rtl/lms_ctrl_pkg.sv
// lms_ctrl_pkg: state encoding and default step/hold constants shared by the LMS controller and filter benches
package lms_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    TRAIN = 3'd2,
    TRACK = 3'd3,
    FRZ   = 3'd4,
    FAULT = 3'd5
  } state_t;
  localparam int HOLD_DEF = 8;
  localparam logic [2:0] MU_TRAIN_DEF = 3'd3;
  localparam logic [2:0] MU_TRACK_DEF = 3'd5;
endpackage

// File: rtl/lms_ctrl_err_mag_cmp.sv
// err_mag_cmp: saturating |e| compared strictly below an unsigned threshold
module err_mag_cmp #(
  parameter int W = 32
) (
  input  logic signed [W-1:0] e,
  input  logic [W-1:0]        thresh,
  output logic                below
);
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX = {1'b0, {(W-1){1'b1}}};
  logic [W-1:0] u, mag;
  assign u = e;
  always_comb begin
    mag = u[W-1] ? ((u == MIN) ? MAX : -u) : u;
    below = mag < thresh;
  end
endmodule

// File: rtl/lms_ctrl.sv
// lms_ctrl: clear/train/track sequencer for the LMS adaptive FIR with freeze, stop and timeout handling
module lms_ctrl import lms_ctrl_pkg::*; #(
  parameter int W2 = 32,
  parameter int L = 16,
  parameter int CNT_W = 16,
  parameter int HOLD = HOLD_DEF,
  parameter logic [2:0] MU_TRAIN = MU_TRAIN_DEF,
  parameter logic [2:0] MU_TRACK = MU_TRACK_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  freeze,
  input  logic                  sample_valid,
  input  logic signed [W2-1:0]  e_in,
  input  logic [W2-1:0]         err_thresh,
  input  logic [CNT_W-1:0]      timeout,
  output logic                  adapt_en,
  output logic [2:0]            mu_shift,
  output logic                  coef_clr,
  output logic [$clog2(L)-1:0]  coef_idx,
  output logic                  converged,
  output logic                  timeout_flag,
  output logic                  busy,
  output logic [2:0]            state
);
  localparam int IW = $clog2(L);
  localparam int RW = $clog2(HOLD + 1);
  state_t cs, ns;
  logic [IW-1:0] idx_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [RW-1:0] run, run_n, run_inc, miss, miss_n, miss_inc;
  logic ft, ft_n, below, trk_n;
  err_mag_cmp #(.W(W2)) u_cmp (.e(e_in), .thresh(err_thresh), .below(below));
  assign state = cs;
  always_comb begin
    ns = cs;
    idx_n = '0;
    cnt_n = cnt;
    run_n = run;
    miss_n = miss;
    ft_n = ft;
    cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
    run_inc = below ? run + 1'b1 : '0;
    miss_inc = below ? '0 : miss + 1'b1;
    if (stop) begin
      ns = IDLE;
      cnt_n = '0;
      run_n = '0;
      miss_n = '0;
      ft_n = 1'b0;
    end else begin
      case (cs)
        IDLE, FAULT: if (start) begin
          ns = CLEAR;
          cnt_n = '0;
          run_n = '0;
          miss_n = '0;
          ft_n = 1'b0;
        end
        CLEAR: begin
          ns = (coef_idx == IW'(L - 1)) ? TRAIN : CLEAR;
          idx_n = (coef_idx == IW'(L - 1)) ? '0 : coef_idx + 1'b1;
        end
        TRAIN: if (freeze) begin
          ns = FRZ;
          ft_n = 1'b0;
        end else if (sample_valid) begin
          cnt_n = cnt_inc;
          run_n = run_inc;
          // convergence outranks a timeout landing on the same sample
          if (run_inc == RW'(HOLD)) begin
            ns = TRACK;
            run_n = '0;
            miss_n = '0;
          end else if (timeout != '0 && cnt_inc == timeout) ns = FAULT;
        end
        TRACK: if (freeze) begin
          ns = FRZ;
          ft_n = 1'b1;
        end else if (sample_valid) begin
          miss_n = miss_inc;
          if (miss_inc == RW'(HOLD)) begin
            ns = TRAIN;
            cnt_n = '0;
            run_n = '0;
            miss_n = '0;
          end
        end
        FRZ: if (!freeze) ns = ft ? TRACK : TRAIN;
        default: ns = IDLE;
      endcase
    end
    trk_n = ns == TRACK || (ns == FRZ && ft_n);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs <= IDLE;
      coef_idx <= '0;
      cnt <= '0;
      run <= '0;
      miss <= '0;
      ft <= 1'b0;
      adapt_en <= 1'b0;
      mu_shift <= MU_TRAIN;
      coef_clr <= 1'b0;
      converged <= 1'b0;
      timeout_flag <= 1'b0;
      busy <= 1'b0;
    end else begin
      cs <= ns;
      coef_idx <= idx_n;
      cnt <= cnt_n;
      run <= run_n;
      miss <= miss_n;
      ft <= ft_n;
      adapt_en <= ns == TRAIN || ns == TRACK;
      mu_shift <= trk_n ? MU_TRACK : MU_TRAIN;
      coef_clr <= ns == CLEAR;
      converged <= trk_n;
      timeout_flag <= ns == FAULT;
      busy <= !(ns == IDLE || ns == FAULT);
    end
  end
endmodule

// File: doc/lms_ctrl.md
# lms_ctrl

Sequencing controller for the 16-tap LMS adaptive FIR. It clears the coefficient bank, runs a fast-step training phase, and detects convergence from the error magnitude. After convergence it drops to a slow-step tracking phase, and it handles freeze, stop and training-timeout faults. It sits beside the filter, takes the filter's registered error output, and drives the filter's coefficient-clear, adapt-enable and step-size shift controls.

## Interface
- W2, 32, error word width (matches filter e_out)
- L, 16, number of taps / coefficients to clear
- CNT_W, 16, sample and timeout counter width
- HOLD, 8, consecutive samples required to enter or leave convergence
- MU_TRAIN, 3, step-size right-shift during clear and training
- MU_TRACK, 5, step-size right-shift during tracking

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  single-cycle request; honoured only in IDLE or FAULT
- stop  in  1  single-cycle request; returns to IDLE from any state
- freeze  in  1  level; suspends adaptation while high
- sample_valid  in  1  one-cycle strobe per filter output sample
- e_in  in  W2 signed  filter error for the current sample
- err_thresh  in  W2 unsigned  convergence magnitude threshold
- timeout  in  CNT_W  maximum training samples; 0 disables the timeout
- adapt_en  out  1  coefficient update enable
- mu_shift  out  3  step-size shift applied to the error in the filter
- coef_clr  out  1  coefficient write-zero strobe
- coef_idx  out  clog2(L)  coefficient index being cleared
- converged  out  1  high in TRACK and in frozen-from-TRACK
- timeout_flag  out  1  sticky; set on entry to FAULT
- busy  out  1  high in every state except IDLE and FAULT
- state  out  3  encoded FSM state

## Operation
- States:
  - IDLE=0: reset state; no adaptation. start → CLEAR.
  - CLEAR=1: coef_clr=1 and coef_idx steps 0..L-1, one per clock, ignoring sample_valid and freeze. After idx L-1 → TRAIN.
  - TRAIN=2: adapt_en=1, mu_shift=MU_TRAIN. Each sample_valid increments sample_cnt (saturating). A run counter increments if |e_in| < err_thresh and resets to 0 otherwise.
    - Run reaching HOLD → TRACK.
    - sample_cnt reaching a nonzero timeout → FAULT.
  - TRACK=3: adapt_en=1, mu_shift=MU_TRACK, converged=1. A miss counter increments on each sample with |e_in| ≥ err_thresh and resets to 0 on each below-threshold sample. Miss reaching HOLD → TRAIN, with sample_cnt, run and converged cleared.
  - FRZ=4: entered from TRAIN or TRACK while freeze=1. adapt_en=0; samples are ignored and counters hold; a from_track bit records the origin. freeze=0 → the origin state, counters resumed.
  - FAULT=5: adapt_en=0, timeout_flag=1. start → CLEAR with timeout_flag cleared; stop → IDLE with timeout_flag cleared.
- Error magnitude: |e_in|, with the most-negative value saturating to 2^(W2-1)-1. The compare against err_thresh is unsigned and strict (<).
- Priority within one cycle: reset > stop > freeze > convergence > timeout > start.
- mu_shift:
  - MU_TRAIN in IDLE, CLEAR, TRAIN and FAULT.
  - In FRZ, MU_TRACK when from_track=1, otherwise MU_TRAIN.
- All outputs are registered and decoded from the next state.

## Timing
- Reset values: state=IDLE, adapt_en=0, coef_clr=0, coef_idx=0, converged=0, timeout_flag=0, busy=0, mu_shift=MU_TRAIN. Internal counters and from_track are 0.
- start sampled high at edge n:
  - CLEAR with coef_clr=1 and coef_idx=0 visible after edge n.
  - coef_idx=L-1 after edge n+L-1.
  - TRAIN with adapt_en=1 and coef_clr=0 after edge n+L.
- HOLD-th consecutive qualifying sample at edge m: TRACK, converged=1 and mu_shift=MU_TRACK after edge m.
- Timeout: the sample that makes sample_cnt equal timeout, at edge m, gives FAULT after edge m. If the same sample also completes convergence, TRACK wins and no fault is raised.
- freeze rising at edge m: FRZ with adapt_en=0 after edge m. Falling at edge k: origin state after edge k.
- stop: IDLE after the sampling edge, with all outputs at reset values.
- Mid-clear stop: the clear aborts and coef_idx returns to 0.
- reset asserted at any point forces reset values immediately (asynchronous), regardless of state.
- start while busy is ignored.

## Structure
- Package lms_ctrl_pkg holds the state enum (3-bit encoding above) and the MU_TRAIN / MU_TRACK / HOLD defaults, shared with the filter's testbench.
- Sub-module err_mag_cmp: combinational saturating absolute value plus strict unsigned compare; returns a below flag. It is instantiated once.
- Top level holds the FSM, the CLEAR index counter, the sample/run/miss counters and the output registers.

## Test plan
All scenarios use L=16, HOLD=8, err_thresh=100, timeout=50.

- Reset then start at edge 0 → coef_idx 0..15 on edges 0..15, coef_clr deasserted and state=TRAIN after edge 16.
- TRAIN with 8 consecutive samples of e_in=±40 → converged=1 and mu_shift=5 after the 8th strobe. Repeat with a single e_in=150 at sample 5 → run resets, and convergence occurs 8 samples after that miss.
- TRAIN with e_in=500 on every sample → FAULT and timeout_flag=1 after the 50th strobe. start → CLEAR and timeout_flag=0.
- e_in=-2^31 in TRACK for 8 samples → saturated magnitude counts as a miss → TRAIN with converged=0.
- freeze raised in TRACK for 20 strobes of e_in=1000 → adapt_en=0, miss counter unchanged. freeze dropped → TRACK, converged still 1.
- stop at CLEAR idx 7 and reset pulse mid-TRAIN → both give IDLE with all outputs at reset values; a start coincident with stop is ignored.
